coeff_ram_loader: RTL
=====================

Name: coeff_ram_loader

Overview:
- Writer side of the filter coefficient-memory interface. Accepts a stream of signed coefficient words over a valid/ready handshake and writes them into an internal coefficient RAM.
- Serves the FIR core's coefficient reads on the same addr→dout timing as the fixed low-pass ROM, with one-cycle registered read latency.
- Replaces the ROM when the filter needs runtime-programmable taps. Sits between the host/config path and CORE_FIR.

Parameters:
- ADDR_W, 10, coefficient address width.
- DATA_W, 16, coefficient word width (signed).
- NUM_TAPS, 1024, number of words per load; legal range 1..2**ADDR_W.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- load_start  input  1  single-cycle request to begin a new coefficient load.
- cff_in  input  DATA_W  coefficient word from the host.
- cff_vld  input  1  cff_in valid.
- cff_rdy  output  1  loader accepts cff_in this cycle.
- sequencing  input  1  FIR core is running a convolution; memory is in use.
- addr  input  ADDR_W  read address from FIR core (cff_ptr).
- dout  output  DATA_W  registered coefficient for addr.
- load_done  output  1  level; a complete, valid coefficient set is resident.
- load_err  output  1  one-cycle pulse; a load was aborted by a restart.

Behaviour:
- Reset: state=IDLE, wr_ptr=0, coef_valid=0, dout=0, cff_rdy=0, load_done=0, load_err=0. RAM contents are not reset. Reset asserted mid-load aborts the load with no further writes.
- FSM states: IDLE, PEND, LOAD.
- IDLE:
  - load_start & !sequencing → LOAD.
  - load_start & sequencing → PEND.
  - On leaving IDLE: coef_valid and load_done clear and wr_ptr=0.
- PEND: waits for sequencing=0, then → LOAD next cycle. A current filter pass is never corrupted.
- LOAD:
  - cff_rdy = !sequencing. When sequencing rises, rdy drops the same cycle and the load stalls; it resumes when sequencing falls.
  - A word transfers only when cff_vld & cff_rdy. It writes RAM[wr_ptr] and increments wr_ptr.
  - On the transfer where wr_ptr==NUM_TAPS-1: → IDLE; coef_valid=1 and load_done=1 from the next cycle; wr_ptr resets to 0.
- load_start while in LOAD or PEND:
  - Restarts the load: wr_ptr=0, state=LOAD if !sequencing else PEND, load_err pulses for 1 cycle.
  - A simultaneous cff_vld&cff_rdy word is discarded, not written.
- Read path:
  - dout <= coef_valid ? RAM[addr] : 0, registered, 1-cycle latency, every cycle regardless of sequencing.
  - The FIR sees zero taps until the first load completes.
- Read/write collision: cannot occur, because writes happen only while coef_valid=0 and then dout is forced 0.
- Handshake rules:
  - The host may hold cff_vld high indefinitely; back-to-back transfers run at 1 word/cycle.
  - The host must not change cff_in while cff_vld & !cff_rdy.
- Widths: no arithmetic on data. wr_ptr is ADDR_W+1 bits wide so NUM_TAPS=2**ADDR_W terminates without wrapping.

Optional Feature:
- COEF_CHECKSUM_EN.
- When defined:
  - Adds output port cff_sum [DATA_W-1:0]: a wrapping 2's-complement sum of all words written in the current load.
  - cff_sum clears to 0 on reset and on any load start or restart, accumulates on each transfer, and holds after load_done.
- When undefined: port and accumulator are absent; behaviour is otherwise identical.

Decomposition:
- Package fir_pkg holds ADDR_W and DATA_W defaults, the loader state enum (IDLE/PEND/LOAD), and NUM_TAPS default, shared with CORE_FIR and the LP/HP wrappers.
- One sub-module, coeff_ram: simple dual-port, 1 write port and 1 synchronous read port, 2**ADDR_W x DATA_W, no reset. The loader holds the FSM, counters, dout masking and the checksum.

Test Plan:
- Reset then idle:
  - Stimulus: addr=5 for 3 cycles.
  - Required: dout=0, load_done=0, cff_rdy=0.
- Full load with NUM_TAPS=4:
  - Stimulus: load_start, then words 0x0001, 0xFFFF, 0x7FFF, 0x8000 back-to-back.
  - Required: cff_rdy high for 4 cycles; load_done=1 the cycle after the 4th.
  - Then addr=0..3 → dout 0x0001, 0xFFFF, 0x7FFF, 0x8000 one cycle later.
  - With COEF_CHECKSUM_EN: cff_sum=0xFFFF.
- Start during sequencing:
  - Stimulus: sequencing=1, pulse load_start, release sequencing after 10 cycles.
  - Required: cff_rdy stays 0 for those 10 cycles (PEND), rises 1 cycle after sequencing falls; dout=0 throughout.
- Mid-load stall:
  - Stimulus: after 2 of 4 words, raise sequencing for 5 cycles with cff_vld held.
  - Required: no writes during the stall; remaining 2 words land at addr 2, 3; final contents are correct.
- Restart abort:
  - Stimulus: after 2 words, pulse load_start with cff_vld=1, then load 4 new words 0x0010..0x0013.
  - Required: load_err pulses once; the concurrent word is dropped; RAM[0..3]=0x0010..0x0013.
- Reset mid-load:
  - Stimulus: assert rst_n=0 asynchronously after word 1.
  - Required: dout=0, load_done=0, state IDLE immediately; a subsequent full load succeeds.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR coefficient-path defaults and loader state encoding
package fir_pkg;

    localparam int FIR_ADDR_W   = 10;
    localparam int FIR_DATA_W   = 16;
    localparam int FIR_NUM_TAPS = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        LOAD = 2'd2
    } ldr_state_t;

endpackage

// File: rtl/coeff_ram.sv
// rtl/coeff_ram.sv - simple dual-port coefficient RAM, one write port, one registered read port
module coeff_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Contents are deliberately unreset so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/coeff_ram_loader.sv
// rtl/coeff_ram_loader.sv - streams host coefficients into coeff_ram and serves FIR reads; COEF_CHECKSUM_EN adds cff_sum
module coeff_ram_loader
    import fir_pkg::*;
#(
    parameter int ADDR_W   = FIR_ADDR_W,
    parameter int DATA_W   = FIR_DATA_W,
    parameter int NUM_TAPS = FIR_NUM_TAPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [DATA_W-1:0] cff_in,
    input  logic              cff_vld,
    output logic              cff_rdy,
    input  logic              sequencing,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout,
    output logic              load_done,
`ifdef COEF_CHECKSUM_EN
    output logic [DATA_W-1:0] cff_sum,
`endif
    output logic              load_err
);

    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(NUM_TAPS - 1);

    ldr_state_t        state, next_state;
    logic [ADDR_W:0]   wr_ptr;
    logic              coef_valid;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic              start_load;
    logic              restart;
    logic              finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A restart takes priority over a concurrent transfer, so that word is dropped.
    always_comb begin
        next_state = state;
        cff_rdy    = 1'b0;
        wr_en      = 1'b0;
        start_load = 1'b0;
        restart    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    start_load = 1'b1;
                    next_state = sequencing ? PEND : LOAD;
                end
            end
            PEND: begin
                if (load_start) begin
                    start_load = 1'b1;
                    restart    = 1'b1;
                    next_state = sequencing ? PEND : LOAD;
                end else if (!sequencing) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                cff_rdy = !sequencing;
                if (load_start) begin
                    start_load = 1'b1;
                    restart    = 1'b1;
                    next_state = sequencing ? PEND : LOAD;
                end else if (cff_vld && cff_rdy) begin
                    wr_en = 1'b1;
                    if (wr_ptr == LAST_PTR) begin
                        finish     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            coef_valid <= 1'b0;
            rd_valid   <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            if (start_load || finish) begin
                wr_ptr <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (start_load) begin
                coef_valid <= 1'b0;
            end else if (finish) begin
                coef_valid <= 1'b1;
            end
            rd_valid <= coef_valid;
            load_err <= restart;
        end
    end

`ifdef COEF_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cff_sum <= '0;
        end else if (start_load) begin
            cff_sum <= '0;
        end else if (wr_en) begin
            cff_sum <= cff_sum + cff_in;
        end
    end
`endif

    coeff_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (cff_in),
        .raddr (addr),
        .rdata (rd_data)
    );

    // Writes only occur while coef_valid is low, so the mask also hides any read/write overlap.
    assign dout      = rd_valid ? rd_data : '0;
    assign load_done = coef_valid;

endmodule
